alu_muldiv: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage; the pipeline stalls on it through a valid/ready handshake.
- Uses one radix-2 shift-add/shift-subtract datapath shared by all eight operations. Divide-by-zero and signed overflow take a one-cycle bypass.

---
 rtl/alu_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// alu_muldiv : iterative radix-2 RV32M/RV64M multiply/divide unit
// Rev 1.0
// ============================================================================
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_res_neg;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_bypass;
    logic [XLEN-1:0] w_bypass_res;

    assign w_accept   = i_valid & (r_state == S_IDLE) & ~i_kill;
    assign w_a_signed = (i_op == c_OP_MULH) | (i_op == c_OP_MULHSU) |
                        (i_op == c_OP_DIV)  | (i_op == c_OP_REM);
    assign w_b_signed = (i_op == c_OP_MULH) | (i_op == c_OP_DIV) | (i_op == c_OP_REM);
    assign w_a_neg    = w_a_signed & i_op_a[XLEN-1];
    assign w_b_neg    = w_b_signed & i_op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (-i_op_a) : i_op_a;
    assign w_b_mag    = w_b_neg ? (-i_op_b) : i_op_b;
    // Remainder follows the dividend; everything else follows the sign product
    assign w_res_neg  = (i_op == c_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = i_op[2] & (i_op_b == '0);
    assign w_ovf      = ((i_op == c_OP_DIV) | (i_op == c_OP_REM)) &
                        (i_op_a == c_MIN_NEG) & (i_op_b == '1);
    assign w_bypass   = w_div_zero | w_ovf;

    always_comb begin
        w_bypass_res = '0;
        if (w_div_zero) begin
            w_bypass_res = i_op[1] ? i_op_a : '1;
        end else if (w_ovf) begin
            w_bypass_res = i_op[1] ? '0 : i_op_a;
        end
    end

    // ------------------------------------------------------------------
    // Shared iteration datapath: r_acc = {hi, lo}
    //   multiply: hi accumulates, lo holds the multiplier, shift right
    //   divide  : hi is the partial remainder, lo the dividend/quotient, shift left
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic              w_fit;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remd;
    logic [XLEN-1:0]   w_final;
    logic              w_last;

    assign w_hi      = r_acc[2*XLEN-1:XLEN];
    assign w_lo      = r_acc[XLEN-1:0];
    assign w_sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_sum, w_lo[XLEN-1:1]};

    assign w_rem_sh  = {w_hi, w_lo[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_fit     = ~w_diff[XLEN];
    assign w_div_nxt = {(w_fit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                        w_lo[XLEN-2:0], w_fit};

    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
    assign w_last    = (r_cnt == CNT_W'(1));

    assign w_prod = r_neg ? (-w_acc_nxt) : w_acc_nxt;
    assign w_quot = r_neg ? (-w_acc_nxt[XLEN-1:0]) : w_acc_nxt[XLEN-1:0];
    assign w_remd = r_neg ? (-w_acc_nxt[2*XLEN-1:XLEN]) : w_acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_op)
            c_OP_MUL:                          w_final = w_prod[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:               w_final = w_quot;
            default:                           w_final = w_remd;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_bypass ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_kill) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_kill || i_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= i_op;
            r_neg <= w_res_neg;
            r_b   <= w_b_mag;
            r_acc <= {{XLEN{1'b0}}, w_a_mag};
            if (w_bypass) begin
                r_cnt    <= '0;
                r_result <= w_bypass_res;
            end else begin
                r_cnt <= CNT_W'(XLEN);
            end
        end else if (r_state == S_BUSY) begin
            if (i_kill) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_result <= w_final;
                end
            end
        end
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// tb_alu_muldiv : randomized self-checking bench for alu_muldiv (XLEN=32)
// Rev 1.0
// ============================================================================
module tb_alu_muldiv;

    localparam int XLEN = 32;

    logic            clk;
    logic            i_rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic            i_kill;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;

    int n_checks = 0;
    int n_errors = 0;

    alu_muldiv #(.XLEN(XLEN)) u_dut (
        .i_clk    (clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .i_kill   (i_kill),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 0;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return XLEN;
    endfunction

    // One full transaction; latency counts clock edges after the accept edge
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [31:0] exp_res;
        logic [31:0] held;
        int          exp_lat;
        int          lat;
        exp_res = ref_res(op, a, b);
        exp_lat = ref_lat(op, a, b);
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_op_a = a; i_op_b = b; i_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0; i_op = 3'($urandom); i_op_a = $urandom; i_op_b = $urandom;
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", 64'(o_result), 64'(exp_res));
        held = o_result;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_result", 64'(o_result), 64'(held));
            chk("hold_ready", 64'(o_ready), 64'd0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("ready_after_hs", 64'(o_ready), 64'd1);
        chk("valid_after_hs", 64'(o_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (i_rst_n) chk("ready_valid_excl", 64'(o_ready & o_valid), 64'd0);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        i_rst_n = 1'b0; i_valid = 1'b0; i_op = '0; i_op_a = '0; i_op_b = '0;
        i_kill = 1'b0; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_result", 64'(o_result), 64'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // Directed cases
        do_op(3'd0, 32'd5, 32'd6, 0);
        do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd5, 32'd1234, 32'd5, 0);
        do_op(3'd7, 32'd1234, 32'd5, 0);
        do_op(3'd5, 32'd1234, 32'd0, 0);
        do_op(3'd7, 32'd1234, 32'd0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5);

        // Kill in BUSY
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd0; i_op_a = 32'd7; i_op_b = 32'd9;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        i_kill = 1'b1;
        @(posedge clk); #1;
        i_kill = 1'b0;
        chk("kill_busy_ready", 64'(o_ready), 64'd1);
        chk("kill_busy_valid", 64'(o_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1;
        end
        chk("kill_no_valid", 64'(seen), 64'd0);
        do_op(3'd0, 32'd3, 32'd4, 0);

        // Kill in DONE (together with i_ready)
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd5; i_op_a = 32'd55; i_op_b = 32'd0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("bypass_valid", 64'(o_valid), 64'd1);
        @(negedge clk);
        i_kill = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_kill = 1'b0; i_ready = 1'b0;
        chk("kill_done_valid", 64'(o_valid), 64'd0);
        chk("kill_done_ready", 64'(o_ready), 64'd1);

        // Kill in IDLE blocks the accept
        @(negedge clk);
        i_valid = 1'b1; i_kill = 1'b1; i_op = 3'd0; i_op_a = 32'd2; i_op_b = 32'd3;
        @(posedge clk); #1;
        i_valid = 1'b0; i_kill = 1'b0;
        chk("kill_idle_ready", 64'(o_ready), 64'd1);
        chk("kill_idle_valid", 64'(o_valid), 64'd0);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd5; i_op_a = 32'd1234; i_op_b = 32'd5;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_result", 64'(o_result), 64'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1);

        // Randomized operations with corner-biased operands
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                4: a = 32'h8000_0000;
                default: ;
            endcase
            do_op(op, a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
